relu_maxpool2x2: RTL and testbench

RELU_MAXPOOL2X2 -- requirements
Module: relu_maxpool2x2

---
 rtl/relu_maxpool2x2_pkg.sv | 16 +
 rtl/relu_maxpool2x2_fmax2.sv | 23 ++
 rtl/relu_maxpool2x2.sv | 122 ++++++++++++
 tb/tb_relu_maxpool2x2.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/relu_maxpool2x2_pkg.sv
// Shared float32 layer constants and helpers for the conv/pool stages.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
package relu_maxpool2x2_pkg;

   localparam int          FP_W     = 32;
   localparam int          SIGN_BIT = 31;
   localparam logic [31:0] POS_ZERO = 32'h0000_0000;

   // Any sign-set pattern, including -0.0, collapses to +0.0 so that every
   // downstream comparison can treat operands as plain unsigned integers.
   function automatic logic [FP_W-1:0] relu_f32(input logic [FP_W-1:0] x);
      return x[SIGN_BIT] ? POS_ZERO : x;
   endfunction

endpackage

// File: rtl/relu_maxpool2x2_fmax2.sv
// relu_fmax2: ReLU both float32 operands, then pick the larger one.
// Latency: combinational. Backpressure: none.
// Ports: a, b (float32 in), y (max of the two rectified operands).
module relu_fmax2
   import relu_maxpool2x2_pkg::*;
(
   input  logic [FP_W-1:0] a,
   input  logic [FP_W-1:0] b,
   output logic [FP_W-1:0] y
);

   logic [FP_W-1:0] a_r;
   logic [FP_W-1:0] b_r;

   always_comb begin
      a_r = relu_f32(a);
      b_r = relu_f32(b);
      // Both operands are non-negative after ReLU, so the IEEE ordering
      // equals the unsigned ordering of the exponent+mantissa bits.
      y   = (a_r[SIGN_BIT-1:0] >= b_r[SIGN_BIT-1:0]) ? a_r : b_r;
   end

endmodule

// File: rtl/relu_maxpool2x2.sv
// ReLU followed by 2x2/stride-2 max pooling over a raster float32 stream.
// Latency: one cycle from the closing input pixel (odd row, odd col) to valid_out.
// Backpressure: none; valid_in bubbles of any length are tolerated.
// Ports: clk, rst (async active-low), valid_in/data_in (pixel stream),
//        valid_out/data_out (pooled pixel), frame_done (with last pooled pixel).
module relu_maxpool2x2
   import relu_maxpool2x2_pkg::*;
#(
   parameter int DATA_WIDTH = FP_W,
   parameter int WIDTH      = 56,
   parameter int HEIGHT     = 56
)
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  valid_in,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic                  valid_out,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  frame_done
);

   localparam int CW       = $clog2(WIDTH);
   localparam int RW       = $clog2(HEIGHT);
   localparam int LBW      = (CW > 1) ? CW - 1 : 1;
   localparam int LB_DEPTH = WIDTH / 2;

   logic [CW-1:0]         col_q, col_d;
   logic [RW-1:0]         row_q, row_d;
   logic [DATA_WIDTH-1:0] hold_q, hold_d;
   logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
   logic                  valid_out_q, valid_out_d;
   logic                  frame_done_q, frame_done_d;

   // One horizontal max per pooled column of the even row.
   logic [DATA_WIDTH-1:0] lb_mem [LB_DEPTH];
   logic [LBW-1:0]        lb_idx;
   logic                  lb_we;
   logic [DATA_WIDTH-1:0] lb_rd;

   logic [DATA_WIDTH-1:0] hmax;
   logic [DATA_WIDTH-1:0] vmax;
   logic                  last_col;
   logic                  last_row;

   assign lb_idx   = LBW'(col_q >> 1);
   assign lb_rd    = lb_mem[lb_idx];
   assign last_col = (col_q == CW'(WIDTH - 1));
   assign last_row = (row_q == RW'(HEIGHT - 1));

   // hold_q is already rectified; the second ReLU inside is a no-op for it.
   relu_fmax2 u_hmax (
      .a (hold_q),
      .b (data_in),
      .y (hmax)
   );

   relu_fmax2 u_vmax (
      .a (lb_rd),
      .b (hmax),
      .y (vmax)
   );

   always_comb begin
      col_d        = col_q;
      row_d        = row_q;
      hold_d       = hold_q;
      data_out_d   = data_out_q;
      valid_out_d  = 1'b0;
      frame_done_d = 1'b0;
      lb_we        = 1'b0;

      if (valid_in) begin
         if (last_col) begin
            col_d = '0;
            row_d = last_row ? '0 : row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end

         if (!col_q[0]) begin
            hold_d = relu_f32(data_in);
         end else if (!row_q[0]) begin
            lb_we = 1'b1;
         end else begin
            valid_out_d  = 1'b1;
            data_out_d   = vmax;
            frame_done_d = last_col && last_row;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         col_q        <= '0;
         row_q        <= '0;
         hold_q       <= POS_ZERO;
         data_out_q   <= POS_ZERO;
         valid_out_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         col_q        <= col_d;
         row_q        <= row_d;
         hold_q       <= hold_d;
         data_out_q   <= data_out_d;
         valid_out_q  <= valid_out_d;
         frame_done_q <= frame_done_d;
      end
   end

   // No reset: every entry is rewritten by the even row before it is read.
   always_ff @(posedge clk) begin
      if (lb_we) begin
         lb_mem[lb_idx] <= hmax;
      end
   end

   assign valid_out  = valid_out_q;
   assign data_out   = data_out_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_relu_maxpool2x2.sv
// Directed bench for relu_maxpool2x2 on a 4x4 map.
// Latency checked: pooled pixel one cycle after its closing input.
// Backpressure: none; bench inserts bubbles to exercise gaps.
module tb_relu_maxpool2x2;

   logic        clk;
   logic        rst;
   logic        valid_in;
   logic [31:0] data_in;
   logic        valid_out;
   logic [31:0] data_out;
   logic        frame_done;

   int          vecs;
   int          miscmp;
   int          fd_cnt;
   logic [31:0] last_exp;

   // frames: 0 = 1.0..16.0, 1 = all -1.0 with one -0.0, 2 = mixed
   logic [31:0] frames [3][16];
   logic [31:0] exps   [3][4];

   relu_maxpool2x2 #(
      .DATA_WIDTH (32),
      .WIDTH      (4),
      .HEIGHT     (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .valid_in   (valid_in),
      .data_in    (data_in),
      .valid_out  (valid_out),
      .data_out   (data_out),
      .frame_done (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         miscmp++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic pix(input string tag, input logic [31:0] d, input logic ev,
                      input logic [31:0] ed, input logic ef);
      @(negedge clk);
      valid_in = 1'b1;
      data_in  = d;
      @(posedge clk);
      #1;
      chk({tag, "_vld"}, 32'(valid_out), 32'(ev));
      chk({tag, "_fd"}, 32'(frame_done), 32'(ef));
      if (ev) last_exp = ed;
      chk({tag, "_dat"}, data_out, last_exp);
      if (frame_done === 1'b1) fd_cnt++;
   endtask

   task automatic bubble(input string tag);
      @(negedge clk);
      valid_in = 1'b0;
      data_in  = 32'hDEAD_BEEF;
      @(posedge clk);
      #1;
      chk({tag, "_vld"}, 32'(valid_out), 32'd0);
      chk({tag, "_dat"}, data_out, last_exp);
   endtask

   // Closing pixels of the four 2x2 windows in a 4x4 raster: 5, 7, 13, 15.
   task automatic frame(input int f, input int n, input bit gaps);
      int k;
      logic ev;
      for (int i = 0; i < n; i++) begin
         ev = (i == 5) || (i == 7) || (i == 13) || (i == 15);
         k  = (i == 5) ? 0 : (i == 7) ? 1 : (i == 13) ? 2 : 3;
         pix($sformatf("f%0d_p%0d", f, i), frames[f][i], ev, exps[f][k], i == 15);
         if (gaps) bubble($sformatf("f%0d_g%0d", f, i));
      end
   endtask

   task automatic reset_now(input string tag);
      rst = 1'b0;
      #1;
      chk({tag, "_vld"}, 32'(valid_out), 32'd0);
      chk({tag, "_fd"}, 32'(frame_done), 32'd0);
      chk({tag, "_dat"}, data_out, 32'h0000_0000);
      last_exp = 32'h0;
      @(negedge clk);
      valid_in = 1'b0;
      rst      = 1'b1;
   endtask

   initial begin
      vecs     = 0;
      miscmp   = 0;
      fd_cnt   = 0;
      last_exp = 32'h0;
      rst      = 1'b0;
      valid_in = 1'b0;
      data_in  = 32'h0;

      frames[0] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                    32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
                    32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000,
                    32'h41500000, 32'h41600000, 32'h41700000, 32'h41800000};
      exps[0]   = '{32'h40C00000, 32'h41000000, 32'h41600000, 32'h41800000};

      for (int i = 0; i < 16; i++) frames[1][i] = 32'hBF800000;
      frames[1][6] = 32'h80000000;
      exps[1]   = '{32'h0, 32'h0, 32'h0, 32'h0};

      // row0: 5,-9,2,7  row1: 1,3,+Inf,4  row2: -1,-2,8,1  row3: 0.5,-0,2,3
      frames[2] = '{32'h40A00000, 32'hC1100000, 32'h40000000, 32'h40E00000,
                    32'h3F800000, 32'h40400000, 32'h7F800000, 32'h40800000,
                    32'hBF800000, 32'hC0000000, 32'h41000000, 32'h3F800000,
                    32'h3F000000, 32'h80000000, 32'h40000000, 32'h40400000};
      exps[2]   = '{32'h40A00000, 32'h7F800000, 32'h3F000000, 32'h41000000};

      // Reset state while held in reset.
      #2;
      chk("rst_vld", 32'(valid_out), 32'd0);
      chk("rst_fd", 32'(frame_done), 32'd0);
      chk("rst_dat", data_out, 32'h0);
      @(negedge clk);
      rst = 1'b1;

      // Reset asserted while valid_out is high: outputs clear in the same cycle.
      frame(0, 6, 1'b0);
      reset_now("rst_mid");

      // Five pixels of a frame, then reset; next frame must be clean.
      frame(0, 5, 1'b0);
      reset_now("rst_p5");
      frame(0, 16, 1'b0);

      // Same frame with a bubble after every pixel.
      frame(0, 16, 1'b1);

      // Two frames back to back.
      fd_cnt = 0;
      frame(0, 16, 1'b0);
      frame(0, 16, 1'b0);
      chk("fd_count", 32'(fd_cnt), 32'd2);

      // All negatives (one -0.0), then mixed signs with +Inf.
      frame(1, 16, 1'b0);
      frame(2, 16, 1'b0);
      bubble("tail");

      $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
      $finish;
   end

endmodule
